// File: rtl/spatial_mult_pkg.sv
// Shared definitions for the spatial (bit-fusion) multiplier job scheduler.
//   - precision mode encodings driven on mult_mode
//   - scheduler FSM state type
//   - packed operand word width derivation
package spatial_mult_pkg;

    localparam logic [1:0] MODE_2B = 2'd0;
    localparam logic [1:0] MODE_4B = 2'd1;
    localparam logic [1:0] MODE_8B = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    // A packed operand word carries PRECISION/L_PRECISION lanes of PRECISION bits.
    function automatic int calc_data_width(input int precision, input int l_precision);
        return (precision / l_precision) * precision;
    endfunction

endpackage

// File: rtl/spatial_mult_sched_valid_delay.sv
// Fixed-depth valid delay line that mirrors the multiplier array pipeline.
// Ports:
//   clk       - clock
//   reset_n   - asynchronous active-low clear of every stage
//   in_valid  - issue strobe entering the array
//   out_valid - the same strobe DEPTH cycles later (array output valid)
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_valid,
    output logic out_valid
);

    // Bit 0 holds the newest strobe, bit DEPTH-1 the oldest.
    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    always_comb begin
        shift_d = DEPTH'({shift_q, in_valid});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign out_valid = shift_q[DEPTH-1];

endmodule

// File: rtl/spatial_mult_sched.sv
// Job scheduler for the recursive spatial multiplier array.
// A job is configured once (mode, signedness, length), then operand word
// pairs stream into the array under valid/ready. Returned fused products are
// accumulated into a single dot product handed out on a result handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The sender holds valid and its payload until that edge; ready never
// depends combinationally on valid.
//
// Ports:
//   cfg_valid/cfg_ready, cfg_mode, cfg_signed, cfg_len - job configuration
//   op_valid/op_ready, op_a, op_b                      - operand stream
//   mult_a, mult_b, mult_mode, mult_signed, mult_valid - array inputs
//   mult_out                                           - array summed product
//   res_valid/res_ready, res_data, res_ovf             - job result
//   busy                                               - any state but IDLE
module spatial_mult_sched
    import spatial_mult_pkg::*;
#(
    parameter int PRECISION    = 8,
    parameter int L_PRECISION  = 2,
    parameter int DATA_WIDTH   = calc_data_width(PRECISION, L_PRECISION),
    parameter int MULT_OUT_W   = 20,
    parameter int MULT_LATENCY = 2,
    parameter int ACC_WIDTH    = 32,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_signed,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] mult_a,
    output logic [DATA_WIDTH-1:0] mult_b,
    output logic [1:0]            mult_mode,
    output logic                  mult_signed,
    output logic                  mult_valid,
    input  logic [MULT_OUT_W-1:0] mult_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  res_ovf,
    output logic                  busy
);

    sched_state_e          state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic                  signed_q, signed_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_WIDTH-1:0]  ret_cnt_q, ret_cnt_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mult_a_q, mult_a_d;
    logic [DATA_WIDTH-1:0] mult_b_q, mult_b_d;
    logic                  mult_valid_q, mult_valid_d;
    logic                  res_valid_q, res_valid_d;
    logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;

    logic                  ret_valid;
    logic [ACC_WIDTH-1:0]  ext_val;
    logic [ACC_WIDTH:0]    sum_w;
    logic                  add_ovf;

    valid_delay #(
        .DEPTH (MULT_LATENCY)
    ) u_valid_delay (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (mult_valid_q),
        .out_valid (ret_valid)
    );

    // Widen the array output to accumulator width (sign- or zero-extended).
    always_comb begin
        ext_val                   = '0;
        ext_val[MULT_OUT_W-1:0]   = mult_out;
        for (int i = MULT_OUT_W; i < ACC_WIDTH; i++) begin
            ext_val[i] = signed_q & mult_out[MULT_OUT_W-1];
        end
    end

    // One extra bit captures the unsigned carry; signed overflow is the
    // usual "same-sign operands, different-sign result" test.
    always_comb begin
        sum_w = {1'b0, acc_q} + {1'b0, ext_val};
        if (signed_q) begin
            add_ovf = (acc_q[ACC_WIDTH-1] == ext_val[ACC_WIDTH-1]) &&
                      (sum_w[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum_w[ACC_WIDTH];
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        signed_d     = signed_q;
        len_d        = len_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        mult_valid_d = 1'b0;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        cfg_ready    = 1'b0;
        op_ready     = 1'b0;

        // Returns may land while still issuing (RUN) as well as in DRAIN.
        if (ret_valid) begin
            acc_d     = sum_w[ACC_WIDTH-1:0];
            ret_cnt_d = ret_cnt_q + LEN_WIDTH'(1);
            if (add_ovf) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    // Code 3 has no distinct fusion level; present it to the
                    // array as full 8-bit precision.
                    mode_d      = (cfg_mode == 2'd3) ? MODE_8B : cfg_mode;
                    signed_d    = cfg_signed;
                    len_d       = cfg_len;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    if (cfg_len == '0) begin
                        state_d     = ST_DONE;
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    mult_a_d     = op_a;
                    mult_b_d     = op_b;
                    mult_valid_d = 1'b1;
                    issue_cnt_d  = issue_cnt_q + LEN_WIDTH'(1);
                    if (issue_cnt_d == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // ret_cnt_q already includes every return, so acc_q is final.
                if (ret_cnt_q == len_q) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    res_data_d  = acc_q;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_2B;
            signed_q     <= 1'b0;
            len_q        <= '0;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_valid_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            signed_q     <= signed_d;
            len_q        <= len_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            mult_valid_q <= mult_valid_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
        end
    end

    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign mult_mode   = mode_q;
    assign mult_signed = signed_q;
    assign mult_valid  = mult_valid_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_ovf     = ovf_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/spatial_mult_sched.md
Name: spatial_mult_sched

Overview:
- Job scheduler for the recursive spatial (bit-fusion) multiplier array and its operand input muxes.
- Accepts a job configuration (precision mode, signedness, vector length), then streams packed operand word pairs into the array under valid/ready.
- Tracks the array's fixed pipeline latency and accumulates the fused products into one dot-product result, returned through a valid/ready handshake.

Parameters:
- PRECISION, 8, top-level operand precision of the array.
- L_PRECISION, 2, lowest fusible precision.
- DATA_WIDTH, (PRECISION/L_PRECISION)*PRECISION, packed operand word width (32 by default).
- MULT_OUT_W, 20, width of the array's summed-product output.
- MULT_LATENCY, 2, cycles from mult_valid to mult_out being valid; must be 1 or more.
- ACC_WIDTH, 32, accumulator and result width; must be at least MULT_OUT_W.
- LEN_WIDTH, 16, width of the job length field.

Ports:
- clk  in  1  clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  job configuration valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_mode  in  2  0 = 2-bit, 1 = 4-bit, 2 = 8-bit, 3 = treated as 8-bit.
- cfg_signed  in  1  operands and products are signed.
- cfg_len  in  LEN_WIDTH  number of operand word pairs in the job.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  high only in RUN.
- op_a  in  DATA_WIDTH  packed A operand word.
- op_b  in  DATA_WIDTH  packed B operand word.
- mult_a  out  DATA_WIDTH  registered A operand to the array.
- mult_b  out  DATA_WIDTH  registered B operand to the array.
- mult_mode  out  2  latched precision mode.
- mult_signed  out  1  latched signedness.
- mult_valid  out  1  one-cycle issue strobe.
- mult_out  in  MULT_OUT_W  array output; sampled only when the delayed valid is high.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  ACC_WIDTH  accumulated dot product.
- res_ovf  out  1  sticky accumulator overflow for the current job.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert): state goes to IDLE. All registered outputs are 0: mult_a, mult_b, mult_mode, mult_signed, mult_valid, res_valid, res_data, res_ovf. Counters, accumulator and the valid delay line are cleared. After reset, cfg_ready=1 and op_ready=0.
- Reset asserted mid-job aborts the job with no result. Any in-flight mult_out is ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, on cfg_valid: latch mode, signed and len; clear acc, res_ovf, issue_cnt and ret_cnt. If len==0, go to DONE with res_data=0. Otherwise go to RUN.
- RUN: each op_valid&&op_ready cycle registers op_a/op_b into mult_a/mult_b, pulses mult_valid the next cycle, and increments issue_cnt. When the handshake that makes issue_cnt==len occurs, go to DRAIN. op_valid low means no issue (bubble); mult_a/mult_b hold their values.
- DRAIN: op_ready=0. Go to DONE in the cycle after ret_cnt reaches len.
- Return path: mult_valid is delayed MULT_LATENCY cycles. On each delayed-valid cycle, acc += ext(mult_out) and ret_cnt++.
  - ext is sign extension when signed, zero extension otherwise.
  - Returns are also accepted while in RUN.
- Accumulator arithmetic: modulo 2^ACC_WIDTH. res_ovf is set on unsigned carry-out (unsigned job) or two's-complement overflow (signed job), and stays set until the next cfg accept.
- DONE: res_valid=1, res_data=acc, both held stable until res_ready. On res_valid&&res_ready, go to IDLE and drop res_valid the next cycle. A new cfg cannot be accepted in the same cycle as the result handshake.
- mult_mode and mult_signed change only on cfg accept; they are stable for the whole job including DRAIN.
- cfg_valid outside IDLE is ignored (cfg_ready=0). op_valid outside RUN is ignored.
- Throughput: one operand pair per cycle sustained. Job latency from the last op handshake to res_valid is 1 + MULT_LATENCY + 1 cycles.

Decomposition:
- Shared package spatial_mult_pkg holds:
  - mode encodings MODE_2B=0, MODE_4B=1, MODE_8B=2;
  - the FSM state enum;
  - the DATA_WIDTH derivation function (PRECISION/L_PRECISION)*PRECISION.
- One sub-module, valid_delay: a parameterised MULT_LATENCY-deep shift register with async active-low clear.
- The accumulator and FSM stay in spatial_mult_sched.

Test Plan:
- Unsigned 8-bit, len=3, returns 10, 20, 30 with continuous op_valid → res_data=60, res_ovf=0, res_valid exactly 4 cycles after the 3rd op handshake.
- Signed 2-bit, len=2, returns 0xFFFFB (-5) then 3 → res_data=0xFFFFFFFE, mult_mode=0 held throughout.
- cfg_len=0 → res_valid in the cycle after cfg accept, res_data=0, mult_valid never pulses.
- Unsigned job with ACC_WIDTH=20, returns 0xFFFFF and 1 → res_data=0, res_ovf=1. The next job with returns 5 and 6 → res_ovf=0, res_data=11.
- op_valid bubbles every other cycle and res_ready held low 5 cycles → result is correct; res_data/res_valid are stable while stalled; cfg_valid pulses during RUN/DONE are ignored.
- reset_n asserted during DRAIN → all outputs 0 immediately. A following 1-element job returning 7 produces res_data=7, with no stale contribution.
